// File: rtl/psk_tx_controller.sv
// Transmit-burst sequencer for the PSK chain: debounced start/abort button, SETTLE/MOD/DRAIN
// sequencing of sine generator and modulator, 4-phase DAC handshake with overrun flag.
// Optional status LED blinker is built only when STATUS_LED_EN is defined.
module psk_tx_controller #(
   parameter int DEBOUNCE_CYC = 16,
   parameter int SETTLE_CYC   = 4,
   parameter int LEN_W        = 16,
   parameter int BLINK_DIV    = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pb,
   input  logic             mode,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             data_rdy,
   input  logic             sym_tick,
   input  logic             sine_rdy,
   input  logic             davdac,
   output logic             sine_rst,
   output logic             sine_clk_en,
   output logic             mod_en,
   output logic             mode_q,
   output logic             dacdav,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic [LEN_W-1:0] sym_cnt,
   output logic             led
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int ST_W = $clog2(SETTLE_CYC + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] MOD    = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   logic [1:0]      state, state_nxt;
   logic            pb_s1, pb_s2, pb_db, pb_db_q, pb_evt;
   logic [DB_W-1:0] db_cnt;
   logic [ST_W-1:0] settle_cnt;
   logic            sym_inc;
   logic [LEN_W-1:0] cnt_nxt;

   // Synchronise the button, require a stable level before accepting it, pulse on press
   always_ff @(posedge clk) begin
      if (rst) begin
         pb_s1   <= 1'b0;
         pb_s2   <= 1'b0;
         pb_db   <= 1'b0;
         pb_db_q <= 1'b0;
         pb_evt  <= 1'b0;
         db_cnt  <= '0;
      end else begin
         pb_s1   <= pb;
         pb_s2   <= pb_s1;
         pb_db_q <= pb_db;
         pb_evt  <= pb_db & ~pb_db_q;
         if (pb_s2 == pb_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            pb_db  <= pb_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // Symbol count with saturation; counting only while the modulator is actually running
   always_comb begin
      sym_inc = (state == MOD) && mod_en && sym_tick && !(&sym_cnt);
      cnt_nxt = sym_cnt + LEN_W'(sym_inc);
   end

   // Next-state decode; a final count and an abort in the same cycle both land in DRAIN
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (pb_evt) state_nxt = SETTLE;
         SETTLE: if (pb_evt) state_nxt = IDLE;
                 else if (settle_cnt == ST_W'(SETTLE_CYC - 1)) state_nxt = MOD;
         MOD:    if (pb_evt || ((burst_len != '0) && (cnt_nxt >= burst_len))) state_nxt = DRAIN;
         DRAIN:  if (!dacdav && !davdac) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and registered control/status outputs, all derived from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         sine_rst    <= 1'b1;
         sine_clk_en <= 1'b0;
         mod_en      <= 1'b0;
         done        <= 1'b0;
         mode_q      <= 1'b0;
         sym_cnt     <= '0;
         settle_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         busy        <= (state_nxt != IDLE);
         sine_rst    <= (state_nxt == IDLE);
         sine_clk_en <= (state_nxt == MOD) && data_rdy;
         mod_en      <= (state_nxt == MOD) && data_rdy;
         done        <= (state == DRAIN) && (state_nxt == IDLE);
         settle_cnt  <= (state == SETTLE) ? settle_cnt + ST_W'(1) : '0;
         if ((state == IDLE) && pb_evt) begin
            mode_q  <= mode;
            sym_cnt <= '0;
         end else if (sym_inc) begin
            sym_cnt <= cnt_nxt;
         end
      end
   end

   // DAC 4-phase handshake; samples arriving mid-handshake are dropped and flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         dacdav  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if ((state == IDLE) && pb_evt)
            overrun <= 1'b0;
         else if ((state == MOD) && sine_rdy && (dacdav || davdac))
            overrun <= 1'b1;
         if (dacdav && davdac)
            dacdav <= 1'b0;
         else if ((state == MOD) && sine_rdy && !dacdav && !davdac)
            dacdav <= 1'b1;
      end
   end

`ifdef STATUS_LED_EN
   logic [BLINK_DIV-1:0] blink_cnt, blink_nxt;

   // Blink counter restarts on every entry to MOD and idles at zero elsewhere
   always_comb begin
      blink_nxt = (state == MOD) ? blink_cnt + BLINK_DIV'(1) : '0;
   end

   // LED: off idle, solid while busy, blinks in MOD when the source has no data
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         led       <= 1'b0;
      end else begin
         blink_cnt <= blink_nxt;
         if (state_nxt == MOD)
            led <= data_rdy | blink_nxt[BLINK_DIV-1];
         else
            led <= (state_nxt != IDLE);
      end
   end
`else
   assign led = 1'b0;
`endif

endmodule
